decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered ID/EX decode stage for the 5-stage RV32IM core; replaces the combinational control decoder.
//  Decodes one 32-bit instruction per accepted beat into a control bundle held in an output register.
//  Adds valid/ready handshake, full M-extension (DIV/REM), illegal-instruction flag, CSR write suppression,
//  load-use hazard stall with bubble insertion, and pipeline flush.
// PARAMETERS
//  XLEN        32  datapath / PC width
//  ENABLE_M    1   1: decode funct7=0000001 R-type as M ops; 0: flag them illegal
//  ENABLE_CSR  1   1: decode SYSTEM CSR ops; 0: flag opcode 1110011 illegal
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst_n          in   1     asynchronous reset, active-low
//  flush          in   1     kill held and incoming instruction (branch redirect / trap)
//  in_valid       in   1     IF/ID has an instruction
//  in_ready       out  1     stage accepts in_instr/in_pc this cycle
//  in_instr       in   32    raw instruction
//  in_pc          in   XLEN  instruction PC
//  ex_load        in   1     instruction currently in EX is a valid load
//  ex_rd          in   5     rd of that instruction
//  out_valid      out  1     output bundle valid
//  out_ready      in   1     EX consumes bundle this cycle
//  out_pc         out  XLEN  registered PC
//  out_rs1/rs2/rd out  5     register indices
//  out_alu_ctrl   out  5     0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND 10 MUL 11 MULH 12 MULHSU 13 MULHU 14 COPYB 15 DIV 16 DIVU 17 REM 18 REMU
//  out_alu_src_a  out  1     0 rs1, 1 PC
//  out_alu_src_b  out  1     0 rs2, 1 imm
//  out_wb_src     out  2     0 ALU 1 Mem 2 PC+4 3 CSR
//  out_reg_write  out  1     rd write enable (forced 0 when rd=0)
//  out_data_read  out  1     load
//  out_data_write out  1     store
//  out_data_strb  out  4     SB 0001, SH 0011, SW 1111 (unshifted)
//  out_mem_funct3 out  3     load/store funct3 for sign/size
//  out_branch     out  1     conditional branch (BRANCH only)
//  out_jump       out  1     JAL or JALR
//  out_csr_write  out  1     CSR write enable
//  out_csr_op     out  3     funct3 of CSR op
//  out_illegal    out  1     illegal/unsupported encoding
// BEHAVIOUR
//  Reset: out_valid=0, every out_* field 0 (out_data_strb 0000); in_ready combinational, 0 during reset.
//  hazard = in_valid & ex_load & ex_rd!=0 & ((ex_rd==rs1 & uses_rs1) | (ex_rd==rs2 & uses_rs2));
//   uses_rs1: all but LUI/AUIPC/JAL/CSR-imm; uses_rs2: R-type, STORE, BRANCH.
//  in_ready = !flush & !hazard & (!out_valid | out_ready).
//  Accept (in_valid & in_ready): bundle registered, out_valid=1 next cycle; latency exactly 1 cycle.
//  Consume without accept (out_valid & out_ready & !accept): out_valid=0 next cycle (bubble).
//  Hazard: one bubble per cycle hazard holds; held bundle still drains if out_ready.
//  Backpressure: out_valid & !out_ready -> all out_* stable, in_ready=0.
//  flush: out_valid=0 next cycle regardless of out_ready/in_valid; nothing accepted that cycle.
//  Illegal (unknown opcode; R-type funct7 not 0000000/0100000/(0000001 if ENABLE_M); SUB/SRA funct7
//   on other funct3; shift-imm funct7 not 0000000/0100000; SYSTEM funct3=000 or 100):
//   out_illegal=1, out_reg_write/data_read/data_write/branch/jump/csr_write=0; still valid bundle.
//  SUB only for R-type funct3=000 funct7[5]=1; I-type funct3=000 always ADD; SRA/SRAI on funct7[5].
//  LUI -> COPYB, src_b=1; AUIPC -> ADD, src_a=1, src_b=1; BRANCH -> SUB, src_b=0; JAL/JALR -> wb_src=2.
//  CSRRS/CSRRC/CSRRSI/CSRRCI with rs1 field=0 -> out_csr_write=0; CSRRW/CSRRWI always write.
//  Async reset mid-transfer: bundle discarded, out_valid=0 immediately.
// TESTING
//  add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_ctrl=0, reg_write=1, rd=3.
//  rem x5,x6,x7 ENABLE_M=1 -> alu_ctrl=17; ENABLE_M=0 -> out_illegal=1, reg_write=0.
//  ex_load=1 ex_rd=1, in add x3,x1,x2 -> in_ready=0 one cycle, out_valid=0 bubble, accepted next cycle.
//  out_ready=0 for 3 cycles with held bundle -> out_* unchanged, in_ready=0; release -> next beat in 1 cycle.
//  csrrs x4,mstatus,x0 -> csr_write=0, wb_src=3; csrrw x4,mstatus,x0 -> csr_write=1.
//  flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, instruction not accepted; rst_n low mid-stream -> all outputs 0.

Source files
------------

// File: rtl/decode_stage.sv
// Registered ID/EX decode stage for RV32IM: decodes one instruction per accepted beat into a
// control bundle with valid/ready handshake, load-use stall and flush.
module decode_stage #(
    parameter int unsigned XLEN       = 32,
    parameter bit          ENABLE_M   = 1'b1,
    parameter bit          ENABLE_CSR = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            ex_load,
    input  logic [4:0]      ex_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_alu_ctrl,
    output logic            out_alu_src_a,
    output logic            out_alu_src_b,
    output logic [1:0]      out_wb_src,
    output logic            out_reg_write,
    output logic            out_data_read,
    output logic            out_data_write,
    output logic [3:0]      out_data_strb,
    output logic [2:0]      out_mem_funct3,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_csr_write,
    output logic [2:0]      out_csr_op,
    output logic            out_illegal
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [4:0] AluAdd   = 5'd0;
    localparam logic [4:0] AluSub   = 5'd1;
    localparam logic [4:0] AluSll   = 5'd2;
    localparam logic [4:0] AluSra   = 5'd7;
    localparam logic [4:0] AluCopyb = 5'd14;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [4:0]      alu_ctrl;
        logic            alu_src_a;
        logic            alu_src_b;
        logic [1:0]      wb_src;
        logic            reg_write;
        logic            data_read;
        logic            data_write;
        logic [3:0]      data_strb;
        logic [2:0]      mem_funct3;
        logic            branch;
        logic            jump;
        logic            csr_write;
        logic [2:0]      csr_op;
        logic            illegal;
    } bundle_t;

    bundle_t    dec, bundle_d, bundle_q;
    logic       out_valid_d, out_valid_q;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic       illegal;
    logic       uses_rs1, uses_rs2, hazard, accept;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        logic [4:0] r;
        case (f3)
            3'd0:    r = AluAdd;
            3'd1:    r = AluSll;
            3'd2:    r = 5'd3;
            3'd3:    r = 5'd4;
            3'd4:    r = 5'd5;
            3'd5:    r = 5'd6;
            3'd6:    r = 5'd8;
            default: r = 5'd9;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] m_alu(input logic [2:0] f3);
        // MUL..MULHU are 10..13, DIV..REMU are 15..18 (14 is COPYB)
        return f3[2] ? (5'd11 + {2'b00, f3}) : (5'd10 + {2'b00, f3});
    endfunction

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        case (opcode)
            OpLui: begin
                dec.alu_ctrl  = AluCopyb;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
            end
            OpAuipc: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
            end
            OpJal, OpJalr: begin
                dec.alu_src_a = (opcode == OpJal);
                dec.alu_src_b = 1'b1;
                dec.wb_src    = 2'd2;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            OpBranch: begin
                dec.alu_ctrl = AluSub;
                dec.branch   = 1'b1;
            end
            OpLoad: begin
                dec.alu_src_b  = 1'b1;
                dec.wb_src     = 2'd1;
                dec.reg_write  = 1'b1;
                dec.data_read  = 1'b1;
                dec.mem_funct3 = funct3;
            end
            OpStore: begin
                dec.alu_src_b  = 1'b1;
                dec.data_write = 1'b1;
                dec.mem_funct3 = funct3;
                case (funct3[1:0])
                    2'b00:   dec.data_strb = 4'b0001;
                    2'b01:   dec.data_strb = 4'b0011;
                    2'b10:   dec.data_strb = 4'b1111;
                    default: dec.data_strb = 4'b0000;
                endcase
            end
            OpImm: begin
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = base_alu(funct3);
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    if (funct7[5]) dec.alu_ctrl = AluSra;
                end
            end
            OpReg: begin
                dec.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec.alu_ctrl = base_alu(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.alu_ctrl = AluSub;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.alu_ctrl = AluSra;
                end else if (funct7 == 7'b0000001 && ENABLE_M) begin
                    dec.alu_ctrl = m_alu(funct3);
                end else begin
                    illegal = 1'b1;
                end
            end
            OpSystem: begin
                if (!ENABLE_CSR || funct3[1:0] == 2'b00) begin
                    illegal = 1'b1;
                end else begin
                    dec.wb_src    = 2'd3;
                    dec.reg_write = 1'b1;
                    dec.csr_op    = funct3;
                    // Set/clear forms with a zero source leave the CSR untouched
                    dec.csr_write = (funct3[1:0] == 2'b01) || (rs1 != 5'd0);
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        if (rd == 5'd0) dec.reg_write = 1'b0;
        dec.pc  = in_pc;
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        dec.rd  = rd;
    end

    assign uses_rs1 = !((opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal) ||
                        (opcode == OpSystem && funct3[2]));
    assign uses_rs2 = (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);
    assign hazard   = in_valid && ex_load && (ex_rd != 5'd0) &&
                      (((ex_rd == rs1) && uses_rs1) || ((ex_rd == rs2) && uses_rs2));
    assign in_ready = rst_n && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = bundle_q.pc;
    assign out_rs1        = bundle_q.rs1;
    assign out_rs2        = bundle_q.rs2;
    assign out_rd         = bundle_q.rd;
    assign out_alu_ctrl   = bundle_q.alu_ctrl;
    assign out_alu_src_a  = bundle_q.alu_src_a;
    assign out_alu_src_b  = bundle_q.alu_src_b;
    assign out_wb_src     = bundle_q.wb_src;
    assign out_reg_write  = bundle_q.reg_write;
    assign out_data_read  = bundle_q.data_read;
    assign out_data_write = bundle_q.data_write;
    assign out_data_strb  = bundle_q.data_strb;
    assign out_mem_funct3 = bundle_q.mem_funct3;
    assign out_branch     = bundle_q.branch;
    assign out_jump       = bundle_q.jump;
    assign out_csr_write  = bundle_q.csr_write;
    assign out_csr_op     = bundle_q.csr_op;
    assign out_illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (full RV32IM+CSR and base-only) against a behavioural
// model, plus directed scenarios with hand-computed expectations.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  alu;
        logic        src_a;
        logic        src_b;
        logic [1:0]  wb;
        logic        rw;
        logic        dr;
        logic        dw;
        logic [3:0]  strb;
        logic [2:0]  mf3;
        logic        br;
        logic        j;
        logic        cw;
        logic [2:0]  cop;
        logic        ill;
    } bundle_t;

    localparam logic [31:0] AddX3  = 32'h002081B3;
    localparam logic [31:0] RemX5  = 32'h027362B3;
    localparam logic [31:0] CsrrsI = 32'h30002273;
    localparam logic [31:0] CsrrwI = 32'h30001273;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, ex_load = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic [4:0]  ex_rd = '0;

    logic a_rdy, a_vld, b_rdy, b_vld;
    logic [31:0] a_pc, b_pc;
    logic [4:0]  a_rs1, a_rs2, a_rd, a_alu, b_rs1, b_rs2, b_rd, b_alu;
    logic        a_sa, a_sb, a_rw, a_dr, a_dw, a_br, a_j, a_cw, a_ill;
    logic        b_sa, b_sb, b_rw, b_dr, b_dw, b_br, b_j, b_cw, b_ill;
    logic [1:0]  a_wb, b_wb;
    logic [3:0]  a_strb, b_strb;
    logic [2:0]  a_mf3, a_cop, b_mf3, b_cop;
    bundle_t     got_a, got_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_CSR(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .ex_load(ex_load), .ex_rd(ex_rd),
        .out_valid(a_vld), .out_ready(out_ready), .out_pc(a_pc), .out_rs1(a_rs1),
        .out_rs2(a_rs2), .out_rd(a_rd), .out_alu_ctrl(a_alu), .out_alu_src_a(a_sa),
        .out_alu_src_b(a_sb), .out_wb_src(a_wb), .out_reg_write(a_rw), .out_data_read(a_dr),
        .out_data_write(a_dw), .out_data_strb(a_strb), .out_mem_funct3(a_mf3),
        .out_branch(a_br), .out_jump(a_j), .out_csr_write(a_cw), .out_csr_op(a_cop),
        .out_illegal(a_ill)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_CSR(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .ex_load(ex_load), .ex_rd(ex_rd),
        .out_valid(b_vld), .out_ready(out_ready), .out_pc(b_pc), .out_rs1(b_rs1),
        .out_rs2(b_rs2), .out_rd(b_rd), .out_alu_ctrl(b_alu), .out_alu_src_a(b_sa),
        .out_alu_src_b(b_sb), .out_wb_src(b_wb), .out_reg_write(b_rw), .out_data_read(b_dr),
        .out_data_write(b_dw), .out_data_strb(b_strb), .out_mem_funct3(b_mf3),
        .out_branch(b_br), .out_jump(b_j), .out_csr_write(b_cw), .out_csr_op(b_cop),
        .out_illegal(b_ill)
    );

    assign got_a = {a_pc, a_rs1, a_rs2, a_rd, a_alu, a_sa, a_sb, a_wb, a_rw, a_dr, a_dw, a_strb,
                    a_mf3, a_br, a_j, a_cw, a_cop, a_ill};
    assign got_b = {b_pc, b_rs1, b_rs2, b_rd, b_alu, b_sa, b_sb, b_wb, b_rw, b_dr, b_dw, b_strb,
                    b_mf3, b_br, b_j, b_cw, b_cop, b_ill};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [4:0] ref_base(input logic [2:0] f3);
        logic [4:0] t [8];
        t = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
        return t[f3];
    endfunction

    function automatic logic [4:0] ref_m(input logic [2:0] f3);
        logic [4:0] t [8];
        t = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd15, 5'd16, 5'd17, 5'd18};
        return t[f3];
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input bit en_m, input bit en_csr);
        bundle_t    b;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit         bad;
        b = '0; bad = 0;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        case (op)
            7'h37: begin b.alu = 5'd14; b.src_b = 1; b.rw = 1; end
            7'h17: begin b.src_a = 1; b.src_b = 1; b.rw = 1; end
            7'h6F: begin b.src_a = 1; b.src_b = 1; b.wb = 2; b.rw = 1; b.j = 1; end
            7'h67: begin b.src_b = 1; b.wb = 2; b.rw = 1; b.j = 1; end
            7'h63: begin b.alu = 5'd1; b.br = 1; end
            7'h03: begin b.src_b = 1; b.wb = 1; b.rw = 1; b.dr = 1; b.mf3 = f3; end
            7'h23: begin
                b.src_b = 1; b.dw = 1; b.mf3 = f3;
                b.strb = (f3 == 0) ? 4'h1 : (f3 == 1) ? 4'h3 : (f3 == 2) ? 4'hF : 4'h0;
            end
            7'h13: begin
                b.src_b = 1; b.rw = 1; b.alu = ref_base(f3);
                if (f3 == 1) bad = (f7 != 0);
                if (f3 == 5) begin
                    bad = (f7 != 0) && (f7 != 7'h20);
                    b.alu = (f7 == 7'h20) ? 5'd7 : 5'd6;
                end
            end
            7'h33: begin
                b.rw = 1;
                if (f7 == 0) b.alu = ref_base(f3);
                else if (f7 == 7'h20 && f3 == 0) b.alu = 5'd1;
                else if (f7 == 7'h20 && f3 == 5) b.alu = 5'd7;
                else if (f7 == 7'h01 && en_m) b.alu = ref_m(f3);
                else bad = 1;
            end
            7'h73: begin
                if (!en_csr || f3 == 0 || f3 == 4) bad = 1;
                else begin
                    b.wb = 3; b.rw = 1; b.cop = f3;
                    b.cw = (f3 == 1) || (f3 == 5) || (ins[19:15] != 0);
                end
            end
            default: bad = 1;
        endcase
        if (bad) begin b = '0; b.ill = 1; end
        b.pc = pc; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
        if (b.rd == 0) b.rw = 0;
        return b;
    endfunction

    function automatic bit ref_hazard(input logic [31:0] ins, input logic v, input logic ld,
                                      input logic [4:0] erd);
        logic [6:0] op;
        bit u1, u2;
        op = ins[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F || (op == 7'h73 && ins[14]));
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return v && ld && erd != 0 && ((erd == ins[19:15] && u1) || (erd == ins[24:20] && u2));
    endfunction

    // Expected state of the output register, advanced once per cycle
    bit      exp_valid = 0;
    bundle_t exp_a = '0, exp_b = '0;

    always @(negedge clk) begin
        bit rdy;
        if (!rst_n) begin
            chk("reset_ready_a", a_rdy, 0);
            chk("reset_valid_a", a_vld, 0);
            chk("reset_bundle_a", got_a, 0);
            chk("reset_bundle_b", got_b, 0);
            exp_valid = 0; exp_a = '0; exp_b = '0;
        end else begin
            rdy = !flush && !ref_hazard(in_instr, in_valid, ex_load, ex_rd) &&
                  (!exp_valid || out_ready);
            chk("in_ready_a", a_rdy, rdy);
            chk("in_ready_b", b_rdy, rdy);
            chk("out_valid_a", a_vld, exp_valid);
            chk("out_valid_b", b_vld, exp_valid);
            if (exp_valid) begin
                chk("bundle_a", got_a, exp_a);
                chk("bundle_b", got_b, exp_b);
            end
            if (flush) exp_valid = 0;
            else if (in_valid && rdy) begin
                exp_valid = 1;
                exp_a = ref_decode(in_instr, in_pc, 1, 1);
                exp_b = ref_decode(in_instr, in_pc, 0, 0);
            end else if (out_ready) exp_valid = 0;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] gen_instr();
        logic [6:0] ops [10];
        logic [6:0] op, f7;
        logic [2:0] f3;
        int k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        k = $urandom_range(0, 10);
        f3 = 3'($urandom);
        f7 = 7'($urandom);
        if (k == 10) begin
            op = 7'($urandom);
            while (op == 7'h0F || op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67 ||
                   op == 7'h63 || op == 7'h03 || op == 7'h23 || op == 7'h13 || op == 7'h33 ||
                   op == 7'h73) op = 7'($urandom);
        end else op = ops[k];
        if (op == 7'h23) f3 = 3'($urandom_range(0, 2));
        if (op == 7'h13 || op == 7'h33) begin
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: ;
            endcase
        end
        return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
                5'($urandom_range(0, 7)), op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        in_pc = 32'h100;
        step(); step();
        @(negedge clk);
        chk("lit_reset_valid", a_vld, 0);
        chk("lit_reset_ready", a_rdy, 0);
        chk("lit_reset_strb", a_strb, 0);
        step();
        rst_n = 1'b1;

        // add x3,x1,x2
        in_valid = 1; in_instr = AddX3; out_ready = 1;
        @(negedge clk);
        chk("lit_add_ready", a_rdy, 1);
        step(); in_valid = 0;
        @(negedge clk);
        chk("lit_add_valid", a_vld, 1);
        chk("lit_add_alu", a_alu, 0);
        chk("lit_add_rw", a_rw, 1);
        chk("lit_add_rd", a_rd, 3);
        chk("lit_add_pc", a_pc, 32'h100);

        // rem x5,x6,x7
        step(); in_valid = 1; in_instr = RemX5;
        step(); in_valid = 0;
        @(negedge clk);
        chk("lit_rem_alu_m", a_alu, 17);
        chk("lit_rem_ill_nom", b_ill, 1);
        chk("lit_rem_rw_nom", b_rw, 0);

        // load-use hazard on x1
        step(); ex_load = 1; ex_rd = 1; in_valid = 1; in_instr = AddX3;
        @(negedge clk);
        chk("lit_haz_ready", a_rdy, 0);
        step(); ex_load = 0;
        @(negedge clk);
        chk("lit_haz_bubble", a_vld, 0);
        chk("lit_haz_ready2", a_rdy, 1);
        step(); in_valid = 0;
        @(negedge clk);
        chk("lit_haz_valid", a_vld, 1);
        chk("lit_haz_rd", a_rd, 3);

        // backpressure for three cycles
        step(); in_valid = 1; in_instr = AddX3; out_ready = 0;
        step(); in_instr = RemX5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_bp_ready", a_rdy, 0);
            chk("lit_bp_valid", a_vld, 1);
            chk("lit_bp_rd", a_rd, 3);
            chk("lit_bp_alu", a_alu, 0);
            step();
        end
        out_ready = 1;
        @(negedge clk);
        chk("lit_bp_release", a_rdy, 1);
        step(); in_valid = 0;
        @(negedge clk);
        chk("lit_bp_next_alu", a_alu, 17);
        chk("lit_bp_next_rd", a_rd, 5);

        // CSR set with x0 source vs CSR write
        step(); in_valid = 1; in_instr = CsrrsI;
        step(); in_instr = CsrrwI;
        @(negedge clk);
        chk("lit_csrrs_cw", a_cw, 0);
        chk("lit_csrrs_wb", a_wb, 3);
        chk("lit_csrrs_ill_nocsr", b_ill, 1);
        step(); in_valid = 0;
        @(negedge clk);
        chk("lit_csrrw_cw", a_cw, 1);

        // flush with a held bundle and a waiting instruction
        step(); in_valid = 1; in_instr = AddX3;
        step(); flush = 1; in_instr = RemX5; out_ready = 0;
        @(negedge clk);
        chk("lit_flush_ready", a_rdy, 0);
        chk("lit_flush_held", a_vld, 1);
        step(); flush = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("lit_flush_valid", a_vld, 0);
        step();
        @(negedge clk);
        chk("lit_flush_noacc", a_vld, 0);

        // asynchronous reset while a bundle is held
        step(); in_valid = 1; in_instr = AddX3; out_ready = 0;
        step(); in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("lit_areset_valid", a_vld, 0);
        chk("lit_areset_rd", a_rd, 0);
        chk("lit_areset_pc", a_pc, 0);
        chk("lit_areset_ready", a_rdy, 0);
        step(); rst_n = 1;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            ex_load   = ($urandom_range(0, 9) < 3);
            ex_rd     = 5'($urandom_range(0, 7));
            in_instr  = gen_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            step();
        end
        in_valid = 0; flush = 0; ex_load = 0; out_ready = 1;
        step(); step();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
